// File: rtl/counter_seq_pkg.sv
// Shared types and constants for the counter sequencer: FSM state encoding
// and the one-shot/periodic mode values.
package counter_seq_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam logic MODE_ONESHOT  = 1'b0;
    localparam logic MODE_PERIODIC = 1'b1;

endpackage

// File: rtl/counter_sequencer_if.sv
// Command/status bundle between the control logic (master) and the
// counter sequencer (slave).
interface counter_sequencer_if #(
    parameter int W = 4
);
    import counter_seq_pkg::*;

    logic         start;
    logic         stop;
    logic         pause;
    logic         mode;
    logic [W-1:0] period;
    logic [W-1:0] count;
    logic         busy;
    logic         tick;
    logic         done;
    state_t       state;

    modport master (
        output start, stop, pause, mode, period,
        input  count, busy, tick, done, state
    );

    modport slave (
        input  start, stop, pause, mode, period,
        output count, busy, tick, done, state
    );

endinterface

// File: rtl/counter_core.sv
// W-bit binary up-counter with asynchronous reset; a synchronous clear
// takes priority over the increment enable.
module counter_core #(
    parameter int W = 4
) (
    input  logic         clock,
    input  logic         clear_n,
    input  logic         sync_clr,
    input  logic         en,
    output logic [W-1:0] q
);

    localparam logic [W-1:0] ONE = W'(1);

    always_ff @(posedge clock or negedge clear_n) begin
        if (!clear_n) begin
            q <= '0;
        end else if (sync_clr) begin
            q <= '0;
        end else if (en) begin
            q <= q + ONE;
        end
    end

endmodule

// File: rtl/counter_sequencer.sv
// Programmable interval sequencer: an FSM that runs counter_core in one-shot
// or periodic mode, pulsing tick on each terminal count.
module counter_sequencer
    import counter_seq_pkg::*;
#(
    parameter int W = 4
) (
    input logic                 clock,
    input logic                 clear_n,
    counter_sequencer_if.slave  bus
);

    state_t       state_q;
    state_t       state_d;
    logic [W-1:0] period_q;
    logic [W-1:0] period_d;
    logic         mode_q;
    logic         mode_d;
    logic         tick_q;
    logic         tick_d;
    logic         sync_clr;
    logic         en;
    logic         terminal;
    logic [W-1:0] count;

    counter_core #(.W(W)) u_core (
        .clock    (clock),
        .clear_n  (clear_n),
        .sync_clr (sync_clr),
        .en       (en),
        .q        (count)
    );

    assign terminal = (count == period_q);

    always_ff @(posedge clock or negedge clear_n) begin
        if (!clear_n) begin
            state_q  <= IDLE;
            period_q <= '0;
            mode_q   <= MODE_ONESHOT;
            tick_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            period_q <= period_d;
            mode_q   <= mode_d;
            tick_q   <= tick_d;
        end
    end

    // Within RUN the command priority is stop > pause > terminal > increment.
    always_comb begin
        state_d  = state_q;
        period_d = period_q;
        mode_d   = mode_q;
        tick_d   = 1'b0;
        sync_clr = 1'b0;
        en       = 1'b0;
        case (state_q)
            IDLE: begin
                sync_clr = 1'b1;
                if (bus.start && !bus.stop) begin
                    state_d  = RUN;
                    period_d = bus.period;
                    mode_d   = bus.mode;
                end
            end
            RUN: begin
                if (bus.stop) begin
                    state_d  = IDLE;
                    sync_clr = 1'b1;
                end else if (bus.pause) begin
                    state_d = PAUSE;
                end else if (terminal) begin
                    sync_clr = 1'b1;
                    tick_d   = 1'b1;
                    if (mode_q == MODE_ONESHOT) begin
                        state_d = DONE;
                    end
                end else begin
                    en = 1'b1;
                end
            end
            PAUSE: begin
                if (bus.stop) begin
                    state_d  = IDLE;
                    sync_clr = 1'b1;
                end else if (!bus.pause) begin
                    state_d = RUN;
                end
            end
            DONE: begin
                sync_clr = 1'b1;
                if (bus.start) begin
                    state_d  = RUN;
                    period_d = bus.period;
                    mode_d   = bus.mode;
                end else begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d  = IDLE;
                sync_clr = 1'b1;
            end
        endcase
    end

    assign bus.count = count;
    assign bus.state = state_q;
    assign bus.busy  = (state_q == RUN) || (state_q == PAUSE);
    assign bus.tick  = tick_q;
    assign bus.done  = (state_q == DONE);

endmodule

// File: tb/tb_counter_sequencer.sv
// Self-checking bench for counter_sequencer: a scripted vector table, directed
// corner sequences, then randomized commands against a behavioural model.
module tb_counter_sequencer;
    import counter_seq_pkg::*;

    localparam logic H = 1'b1;
    localparam logic L = 1'b0;

    logic clock;
    logic clear_n;
    int   pass_count;
    int   check_count;

    counter_sequencer_if #(.W(4)) bus ();

    counter_sequencer #(.W(4)) dut (
        .clock   (clock),
        .clear_n (clear_n),
        .bus     (bus.slave)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        logic       start;
        logic       stop;
        logic       pause;
        logic       mode;
        logic [3:0] period;
        logic [3:0] exp_count;
        logic [1:0] exp_state;
        logic       exp_tick;
        logic       exp_done;
        logic       exp_busy;
    } vec_t;

    vec_t vecs [27];

    int  m_count;
    int  m_per;
    bit  m_periodic;
    bit  m_active;
    bit  m_paused;
    bit  m_finish;
    bit  m_tick;

    function automatic vec_t mk(input logic s, input logic st, input logic pa,
                                input logic m, input logic [3:0] per,
                                input logic [3:0] ec, input logic [1:0] es,
                                input logic et, input logic ed, input logic eb);
        vec_t v;
        v.start = s;  v.stop = st; v.pause = pa; v.mode = m; v.period = per;
        v.exp_count = ec; v.exp_state = es; v.exp_tick = et;
        v.exp_done = ed; v.exp_busy = eb;
        return v;
    endfunction

    task automatic check_output(input string name, input int actual, input int expected);
        check_count++;
        if (actual == expected) begin
            pass_count++;
        end else begin
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    task automatic apply_stimulus(input logic s, input logic st, input logic pa,
                                  input logic m, input logic [3:0] per);
        bus.start  = s;
        bus.stop   = st;
        bus.pause  = pa;
        bus.mode   = m;
        bus.period = per;
    endtask

    task automatic cycle();
        @(posedge clock);
        #1;
    endtask

    task automatic check_all(input string tag, input int c, input int s,
                             input int t, input int d, input int b);
        check_output({tag, " count"}, int'(bus.count), c);
        check_output({tag, " state"}, int'(bus.state), s);
        check_output({tag, " tick"},  int'(bus.tick),  t);
        check_output({tag, " done"},  int'(bus.done),  d);
        check_output({tag, " busy"},  int'(bus.busy),  b);
    endtask

    // Reference behaviour: a run is "active" (possibly paused); a finished
    // one-shot spends one cycle in a finish flag before going idle or restarting.
    task automatic model_step(input logic s, input logic st, input logic pa,
                              input logic m, input logic [3:0] per);
        bit was_finish;
        was_finish = m_finish;
        m_tick   = 1'b0;
        m_finish = 1'b0;
        if (was_finish || !m_active) begin
            if (s && (was_finish || !st)) begin
                m_active   = 1'b1;
                m_paused   = 1'b0;
                m_per      = int'(per);
                m_periodic = m;
            end
            m_count = 0;
        end else if (st) begin
            m_active = 1'b0;
            m_paused = 1'b0;
            m_count  = 0;
        end else if (m_paused) begin
            m_paused = pa;
        end else if (pa) begin
            m_paused = 1'b1;
        end else if (m_count == m_per) begin
            m_count = 0;
            m_tick  = 1'b1;
            if (!m_periodic) begin
                m_active = 1'b0;
                m_finish = 1'b1;
            end
        end else begin
            m_count = (m_count + 1) % 16;
        end
    endtask

    function automatic int model_state();
        if (m_finish)      return 3;
        else if (!m_active) return 0;
        else if (m_paused)  return 2;
        else                return 1;
    endfunction

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation still running, expected $finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        pass_count  = 0;
        check_count = 0;
        apply_stimulus(L, L, L, L, 4'd0);
        clear_n = 1'b0;

        vecs[0]  = mk(H, L, L, H, 4'd3, 4'd0, 2'd1, L, L, H);
        vecs[1]  = mk(L, L, L, H, 4'd3, 4'd1, 2'd1, L, L, H);
        vecs[2]  = mk(L, L, L, H, 4'd3, 4'd2, 2'd1, L, L, H);
        vecs[3]  = mk(L, L, L, H, 4'd3, 4'd3, 2'd1, L, L, H);
        vecs[4]  = mk(L, L, L, H, 4'd3, 4'd0, 2'd1, H, L, H);
        vecs[5]  = mk(L, L, L, H, 4'd3, 4'd1, 2'd1, L, L, H);
        vecs[6]  = mk(L, L, L, H, 4'd3, 4'd2, 2'd1, L, L, H);
        vecs[7]  = mk(L, L, L, H, 4'd3, 4'd3, 2'd1, L, L, H);
        vecs[8]  = mk(L, L, L, H, 4'd3, 4'd0, 2'd1, H, L, H);
        vecs[9]  = mk(L, H, L, H, 4'd3, 4'd0, 2'd0, L, L, L);
        vecs[10] = mk(H, L, L, L, 4'd2, 4'd0, 2'd1, L, L, H);
        vecs[11] = mk(L, L, L, L, 4'd2, 4'd1, 2'd1, L, L, H);
        vecs[12] = mk(L, L, L, L, 4'd2, 4'd2, 2'd1, L, L, H);
        vecs[13] = mk(L, L, L, L, 4'd2, 4'd0, 2'd3, H, H, L);
        vecs[14] = mk(L, L, L, L, 4'd2, 4'd0, 2'd0, L, L, L);
        vecs[15] = mk(H, H, L, H, 4'd5, 4'd0, 2'd0, L, L, L);
        vecs[16] = mk(H, L, L, H, 4'd7, 4'd0, 2'd1, L, L, H);
        vecs[17] = mk(L, L, L, H, 4'd7, 4'd1, 2'd1, L, L, H);
        vecs[18] = mk(L, L, L, H, 4'd7, 4'd2, 2'd1, L, L, H);
        vecs[19] = mk(L, L, L, H, 4'd7, 4'd3, 2'd1, L, L, H);
        vecs[20] = mk(L, L, L, H, 4'd7, 4'd4, 2'd1, L, L, H);
        vecs[21] = mk(L, L, H, H, 4'd7, 4'd4, 2'd2, L, L, H);
        vecs[22] = mk(L, L, H, H, 4'd7, 4'd4, 2'd2, L, L, H);
        vecs[23] = mk(L, L, H, H, 4'd7, 4'd4, 2'd2, L, L, H);
        vecs[24] = mk(L, L, L, H, 4'd7, 4'd4, 2'd1, L, L, H);
        vecs[25] = mk(L, L, L, H, 4'd7, 4'd5, 2'd1, L, L, H);
        vecs[26] = mk(L, H, H, H, 4'd7, 4'd0, 2'd0, L, L, L);

        #12;
        check_all("reset", 0, 0, 0, 0, 0);
        @(negedge clock);
        clear_n = 1'b1;

        for (int i = 0; i < 27; i++) begin
            apply_stimulus(vecs[i].start, vecs[i].stop, vecs[i].pause,
                           vecs[i].mode, vecs[i].period);
            cycle();
            check_all($sformatf("vec%0d", i), int'(vecs[i].exp_count),
                      int'(vecs[i].exp_state), int'(vecs[i].exp_tick),
                      int'(vecs[i].exp_done), int'(vecs[i].exp_busy));
        end

        // Start held through DONE relatches a new period/mode.
        apply_stimulus(H, L, L, L, 4'd0);
        cycle();
        check_all("oneshot0 start", 0, 1, 0, 0, 1);
        apply_stimulus(H, L, L, H, 4'd2);
        cycle();
        check_all("oneshot0 done", 0, 3, 1, 1, 0);
        cycle();
        check_all("restart from done", 0, 1, 0, 0, 1);
        apply_stimulus(L, L, L, L, 4'd0);
        cycle(); cycle(); cycle();
        check_all("restart periodic wrap", 0, 1, 1, 0, 1);
        apply_stimulus(L, H, L, L, 4'd0);
        cycle();
        check_all("restart stop", 0, 0, 0, 0, 0);

        apply_stimulus(H, L, L, H, 4'd0);
        cycle();
        apply_stimulus(L, L, L, H, 4'd0);
        for (int i = 0; i < 4; i++) begin
            cycle();
            check_all($sformatf("period0 c%0d", i), 0, 1, 1, 0, 1);
        end
        apply_stimulus(L, H, L, H, 4'd0);
        cycle();

        apply_stimulus(H, L, L, H, 4'd15);
        cycle();
        apply_stimulus(L, L, L, H, 4'd15);
        for (int i = 0; i < 15; i++) cycle();
        check_all("p15 top", 15, 1, 0, 0, 1);
        cycle();
        check_all("p15 wrap", 0, 1, 1, 0, 1);
        apply_stimulus(L, H, L, H, 4'd15);
        cycle();

        apply_stimulus(H, L, L, H, 4'd3);
        cycle();
        apply_stimulus(L, L, L, L, 4'd9);
        cycle(); cycle(); cycle();
        check_all("midrun period c3", 3, 1, 0, 0, 1);
        cycle();
        check_all("midrun period tick", 0, 1, 1, 0, 1);
        apply_stimulus(L, H, L, L, 4'd9);
        cycle();

        apply_stimulus(H, L, L, H, 4'd7);
        cycle();
        apply_stimulus(L, L, L, H, 4'd7);
        for (int i = 0; i < 7; i++) cycle();
        check_all("p7 at term", 7, 1, 0, 0, 1);
        apply_stimulus(L, L, H, H, 4'd7);
        for (int i = 0; i < 3; i++) begin
            cycle();
            check_all($sformatf("pause at term %0d", i), 7, 2, 0, 0, 1);
        end
        apply_stimulus(L, L, L, H, 4'd7);
        cycle();
        check_all("unpause", 7, 1, 0, 0, 1);
        cycle();
        check_all("unpause tick", 0, 1, 1, 0, 1);
        apply_stimulus(L, H, L, H, 4'd7);
        cycle();

        // Asynchronous reset between edges while running at count 5.
        apply_stimulus(H, L, L, H, 4'd7);
        cycle();
        apply_stimulus(L, L, L, H, 4'd7);
        for (int i = 0; i < 5; i++) cycle();
        check_all("pre-reset", 5, 1, 0, 0, 1);
        #2;
        clear_n = 1'b0;
        #1;
        check_all("async reset", 0, 0, 0, 0, 0);
        @(negedge clock);
        clear_n = 1'b1;
        cycle();
        check_all("post reset", 0, 0, 0, 0, 0);

        m_count = 0; m_per = 0; m_periodic = 1'b0;
        m_active = 1'b0; m_paused = 1'b0; m_finish = 1'b0; m_tick = 1'b0;
        for (int i = 0; i < 600; i++) begin
            logic       s, st, pa, m;
            logic [3:0] per;
            s   = ($urandom_range(0, 5) == 0);
            st  = ($urandom_range(0, 24) == 0);
            pa  = ($urandom_range(0, 9) < 2);
            m   = 1'($urandom_range(0, 1));
            per = ($urandom_range(0, 1) == 1) ? 4'($urandom_range(0, 4))
                                              : 4'($urandom_range(0, 15));
            apply_stimulus(s, st, pa, m, per);
            @(posedge clock);
            model_step(s, st, pa, m, per);
            #1;
            check_all($sformatf("rnd%0d", i), m_count, model_state(), int'(m_tick),
                      int'(m_finish), int'(m_active));
        end

        $display("%0d/%0d checks passed", pass_count, check_count);
        $finish;
    end

endmodule
